// File: rtl/dbf_scan_sequencer.sv
// Per-frame scan-line sequencer driving LUT load, TX burst, settle gap and RX window to all channels.
// Optional overrun counter built only when DBF_SEQ_OVERRUN_CNT_EN is defined.
module dbf_scan_sequencer #(
    parameter int unsigned ADDR_WD       = 10,
    parameter int unsigned RX_SAMPLES    = 1024,
    parameter int unsigned TX_CYCLES     = 64,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned NUM_LINES     = 128,
    parameter int unsigned LINE_WD       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               abort,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               tx_en,
    output logic               start,
    output logic [LINE_WD-1:0] line_idx,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done,
    output logic [7:0]         overrun_cnt
);

    localparam int unsigned CNT_WD = ADDR_WD + 1;

    localparam logic [CNT_WD-1:0]  RxReload     = CNT_WD'(RX_SAMPLES - 1);
    localparam logic [CNT_WD-1:0]  TxReload     = CNT_WD'(TX_CYCLES - 1);
    localparam logic [CNT_WD-1:0]  SettleReload = CNT_WD'(SETTLE_CYCLES - 1);
    localparam logic [LINE_WD-1:0] LastLine     = LINE_WD'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StTx,
        StSettle,
        StRx,
        StNext
    } state_e;

    state_e            state_q;
    logic [CNT_WD-1:0] cnt_q;
    logic              cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // State and every output are updated together so each output is a plain flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            line_idx     <= '0;
            busy         <= 1'b0;
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else if (abort && (state_q != StIdle)) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            line_idx     <= '0;
            busy         <= 1'b0;
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (frame_start && !abort) begin
                        state_q      <= StLoad;
                        cnt_q        <= RxReload;
                        dbf_lut_addr <= '0;
                        dbf_lut_we   <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                StLoad: begin
                    if (cnt_zero) begin
                        state_q      <= StTx;
                        cnt_q        <= TxReload;
                        dbf_lut_addr <= '0;
                        dbf_lut_we   <= 1'b0;
                        tx_en        <= 1'b1;
                    end else begin
                        cnt_q        <= cnt_q - CNT_WD'(1);
                        dbf_lut_addr <= dbf_lut_addr + ADDR_WD'(1);
                    end
                end
                StTx: begin
                    if (cnt_zero) begin
                        state_q <= StSettle;
                        cnt_q   <= SettleReload;
                        tx_en   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_WD'(1);
                    end
                end
                StSettle: begin
                    if (cnt_zero) begin
                        state_q      <= StRx;
                        cnt_q        <= RxReload;
                        dbf_lut_addr <= '0;
                        start        <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_WD'(1);
                    end
                end
                StRx: begin
                    if (cnt_zero) begin
                        state_q      <= StNext;
                        cnt_q        <= '0;
                        dbf_lut_addr <= '0;
                        start        <= 1'b0;
                        line_done    <= 1'b1;
                        frame_done   <= (line_idx == LastLine);
                    end else begin
                        cnt_q        <= cnt_q - CNT_WD'(1);
                        dbf_lut_addr <= dbf_lut_addr + ADDR_WD'(1);
                    end
                end
                StNext: begin
                    if (line_idx == LastLine) begin
                        state_q  <= StIdle;
                        line_idx <= '0;
                        busy     <= 1'b0;
                    end else begin
                        state_q      <= StLoad;
                        cnt_q        <= RxReload;
                        line_idx     <= line_idx + LINE_WD'(1);
                        dbf_lut_addr <= '0;
                        dbf_lut_we   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef DBF_SEQ_OVERRUN_CNT_EN
    logic frame_accept;

    assign frame_accept = frame_start && !abort && (state_q == StIdle);

    // Counts rejected starts, including those landing on the final NEXT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_cnt <= 8'd0;
        end else if (frame_accept) begin
            overrun_cnt <= 8'd0;
        end else if (frame_start && busy && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule
